laser_point_feeder: RTL and testbench

LASER_POINT_FEEDER -- requirements
Module: laser_point_feeder

---
 rtl/laser_pkg.sv | 13 +
 rtl/laser_point_feeder_if.sv | 28 ++
 rtl/laser_point_bank.sv | 25 ++
 rtl/laser_point_feeder.sv | 148 ++++++++++++++
 tb/tb_laser_point_feeder.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_pkg.sv
// Constants and replay-state encoding shared by the point feeder and the solver.
package laser_pkg;

  localparam int NPTS    = 40;
  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } replay_state_t;

endpackage

// File: rtl/laser_point_feeder_if.sv
// Host-load and solver-replay signals of the laser point feeder.
// IN_*: a point transfers on a rising edge where IN_VALID && IN_READY; IN_READY never depends on IN_VALID.
interface laser_point_feeder_if #(
  parameter int COORD_W = laser_pkg::COORD_W
);

  logic               IN_VALID;
  logic               IN_READY;
  logic [COORD_W-1:0] IN_X;
  logic [COORD_W-1:0] IN_Y;
  logic               IN_LAST;
  logic               SOL_VALID;
  logic [COORD_W-1:0] SOL_X;
  logic [COORD_W-1:0] SOL_Y;
  logic               SOL_DONE;
  logic               FRAME_ERR;

  modport slave (
    input  IN_VALID, IN_X, IN_Y, IN_LAST, SOL_DONE,
    output IN_READY, SOL_VALID, SOL_X, SOL_Y, FRAME_ERR
  );

  modport master (
    output IN_VALID, IN_X, IN_Y, IN_LAST, SOL_DONE,
    input  IN_READY, SOL_VALID, SOL_X, SOL_Y, FRAME_ERR
  );

endinterface

// File: rtl/laser_point_bank.sv
// One frame of points: synchronous single write port, asynchronous single read port.
module laser_point_bank #(
  parameter int NPTS  = laser_pkg::NPTS,
  parameter int DW    = 2 * laser_pkg::COORD_W,
  parameter int IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [DW-1:0]    rdata_o
);

  logic [DW-1:0] mem_q [NPTS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/laser_point_feeder.sv
// Ping-pong point buffer: the host fills one bank while the other is replayed to the solver,
// NPTS points per frame, released by the solver's SOL_DONE pulse.
module laser_point_feeder #(
  parameter int NPTS    = laser_pkg::NPTS,
  parameter int COORD_W = laser_pkg::COORD_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  laser_point_feeder_if.slave      bus,
  output laser_pkg::replay_state_t dbg_state_o
);

  import laser_pkg::*;

  localparam int               IDX_W    = (NPTS > 1) ? $clog2(NPTS) : 1;
  localparam int               DW       = 2 * COORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_nxt;
  logic               rdy_en_q;
  logic               err_q, err_d;
  replay_state_t      state_q;
  logic               sol_valid_q;
  logic [COORD_W-1:0] sol_x_q, sol_y_q;

  logic               in_ready, accept, at_last, frame_ok, frame_bad, release_bank;
  logic [1:0]         bank_we;
  logic [DW-1:0]      bank_rdata [2];
  logic [DW-1:0]      rd_word;

  // rdy_en_q keeps IN_READY low during reset and until the first edge after release.
  assign in_ready     = rdy_en_q & ~full_q[wr_bank_q];
  assign accept       = bus.IN_VALID & in_ready;
  assign at_last      = (wr_idx_q == LAST_IDX);
  assign frame_ok     = accept & at_last & bus.IN_LAST;
  assign frame_bad    = accept & (at_last ^ bus.IN_LAST);
  assign release_bank = (state_q == WAIT_DONE) & bus.SOL_DONE;
  assign rd_idx_nxt   = (rd_idx_q == LAST_IDX) ? '0 : rd_idx_q + 1'b1;
  assign rd_word      = bank_rdata[rd_bank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = accept & (wr_bank_q == 1'(b));

    laser_point_bank #(
      .NPTS  (NPTS),
      .DW    (DW),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk_i   (CLK),
      .we_i    (bank_we[b]),
      .waddr_i (wr_idx_q),
      .wdata_i ({bus.IN_X, bus.IN_Y}),
      .raddr_i (rd_idx_q),
      .rdata_o (bank_rdata[b])
    );
  end

  // Setting FULL on the write bank and clearing it on the read bank are independent updates.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    err_d     = 1'b0;
    if (frame_ok) begin
      full_d[wr_bank_q] = 1'b1;
      wr_idx_d          = '0;
      wr_bank_d         = ~wr_bank_q;
    end else if (frame_bad) begin
      wr_idx_d = '0;
      err_d    = 1'b1;
    end else if (accept) begin
      wr_idx_d = wr_idx_q + 1'b1;
    end
    if (release_bank) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rdy_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      rdy_en_q  <= 1'b1;
      err_q     <= err_d;
    end
  end

  // Each output register holds the entry being presented; rd_idx_q points at the next one
  // and is back at 0 once entry NPTS-1 has been loaded.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      rd_idx_q    <= '0;
      sol_valid_q <= 1'b0;
      sol_x_q     <= '0;
      sol_y_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q              <= STREAM;
            sol_valid_q          <= 1'b1;
            {sol_x_q, sol_y_q}   <= rd_word;
            rd_idx_q             <= rd_idx_nxt;
          end
        end
        STREAM: begin
          if (rd_idx_q == '0) begin
            state_q     <= WAIT_DONE;
            sol_valid_q <= 1'b0;
          end else begin
            {sol_x_q, sol_y_q} <= rd_word;
            rd_idx_q           <= rd_idx_nxt;
          end
        end
        WAIT_DONE: begin
          if (bus.SOL_DONE) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.SOL_VALID = sol_valid_q;
  assign bus.SOL_X     = sol_x_q;
  assign bus.SOL_Y     = sol_y_q;
  assign bus.FRAME_ERR = err_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_laser_point_feeder.sv
// Bench for laser_point_feeder: frame vector table plus back-to-back, mid-stream SOL_DONE
// and mid-stream reset sequences; a negedge monitor scores every solver point.
module tb_laser_point_feeder;
  import laser_pkg::*;

  localparam int N          = NPTS;
  localparam int CW         = COORD_W;
  localparam int DW         = 2 * CW;
  localparam int RUN_BUDGET = 4 * NPTS + 20;

  typedef struct {
    int len;
    int last_at;
    int xm;
    int xo;
    int ym;
    int yo;
    bit exp_err;
    bit exp_stream;
  } frame_vec_t;

  // clock / reset
  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  replay_state_t dbg_state;
  int            cyc   = 0;

  laser_point_feeder_if #(.COORD_W(CW)) bus ();

  laser_point_feeder #(
    .NPTS    (N),
    .COORD_W (CW)
  ) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // scoreboard state
  int            checks     = 0;
  int            errors     = 0;
  logic [DW-1:0] exp_q[$];
  int            runs_done  = 0;
  int            err_pulses = 0;
  int            run_len    = 0;

  frame_vec_t vecs [7];
  frame_vec_t fa, fb, fc, fd, fe;
  int         r0, c0;

  function automatic logic [31:0] w1(input logic b);
    return {31'd0, b};
  endfunction

  function automatic logic [31:0] wc(input logic [CW-1:0] v);
    return {{(32-CW){1'b0}}, v};
  endfunction

  function automatic logic [CW-1:0] coord(input int i, input int m, input int o);
    return CW'((i * m + o) & ((1 << CW) - 1));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor_loop();
    logic [DW-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run_len = 0;
      end else begin
        if (bus.FRAME_ERR) err_pulses++;
        if (bus.SOL_VALID) begin
          run_len++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sol_point: got x=0x%0h y=0x%0h, expected no point", bus.SOL_X, bus.SOL_Y);
          end else begin
            exp_w = exp_q.pop_front();
            check("sol_point", {{(32-DW){1'b0}}, bus.SOL_X, bus.SOL_Y}, {{(32-DW){1'b0}}, exp_w});
          end
        end else if (run_len != 0) begin
          check("stream_len", run_len, N);
          runs_done++;
          run_len = 0;
        end
      end
    end
  endtask

  // driver tasks: entered and left just after a falling edge
  task automatic send_point(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic last);
    int guard;
    guard        = 0;
    bus.IN_VALID = 1'b1;
    bus.IN_X     = x;
    bus.IN_Y     = y;
    bus.IN_LAST  = last;
    while (bus.IN_READY !== 1'b1 && guard < RUN_BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= RUN_BUDGET) check("in_ready_timeout", w1(bus.IN_READY), 32'd1);
    @(negedge clk);
    bus.IN_VALID = 1'b0;
    bus.IN_LAST  = 1'b0;
  endtask

  task automatic send_frame(input frame_vec_t v, input bit push);
    logic [CW-1:0] x, y;
    for (int i = 0; i < v.len; i++) begin
      x = coord(i, v.xm, v.xo);
      y = coord(i, v.ym, v.yo);
      if (push) exp_q.push_back({x, y});
      send_point(x, y, (i == v.last_at));
    end
  endtask

  task automatic wait_runs(input int target);
    int guard;
    guard = 0;
    while (runs_done < target && guard < RUN_BUDGET) begin
      @(negedge clk);
      guard++;
    end
    check("stream_end_seen", runs_done, target);
  endtask

  task automatic pulse_done();
    bus.SOL_DONE = 1'b1;
    @(negedge clk);
    bus.SOL_DONE = 1'b0;
  endtask

  task automatic apply_frame(input frame_vec_t v);
    int rs, es;
    rs = runs_done;
    es = err_pulses;
    send_frame(v, v.exp_stream);
    check("frame_err_pulse", w1(bus.FRAME_ERR), w1(v.exp_err));
    check("sol_valid_lat1", w1(bus.SOL_VALID), 32'd0);
    @(negedge clk);
    check("frame_err_width", w1(bus.FRAME_ERR), 32'd0);
    check("sol_valid_lat2", w1(bus.SOL_VALID), w1(v.exp_stream));
    if (v.exp_stream) begin
      wait_runs(rs + 1);
      check("state_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
      pulse_done();
      check("state_idle", 32'(dbg_state), 32'(IDLE));
    end else begin
      repeat (N + 4) @(negedge clk);
      check("no_stream", runs_done, rs);
    end
    check("err_pulse_count", err_pulses - es, v.exp_err ? 1 : 0);
  endtask

  initial begin
    // len, last_at, xm, xo, ym, yo, exp_err, exp_stream
    vecs[0] = '{11, 10, 1, 0, 3, 0, 1'b1, 1'b0};
    vecs[1] = '{N, N - 1, 1, 0, 3, 0, 1'b0, 1'b1};
    vecs[2] = '{N, -1, 2, 1, 1, 5, 1'b1, 1'b0};
    vecs[3] = '{N - 1, N - 2, 1, 1, 1, 1, 1'b1, 1'b0};
    vecs[4] = '{N, N - 1, 5, 3, 7, 1, 1'b0, 1'b1};
    vecs[5] = '{1, 0, 1, 0, 1, 0, 1'b1, 1'b0};
    vecs[6] = '{N, N - 1, 3, 7, 11, 2, 1'b0, 1'b1};
    fa = '{N, N - 1, 1, 2, 1, 9, 1'b0, 1'b1};
    fb = '{N, N - 1, 7, 4, 3, 3, 1'b0, 1'b1};
    fc = '{N, N - 1, 9, 5, 13, 6, 1'b0, 1'b1};
    fd = '{N, N - 1, 1, 3, 2, 1, 1'b0, 1'b1};
    fe = '{N, N - 1, 11, 1, 5, 12, 1'b0, 1'b1};

    bus.IN_VALID = 1'b0;
    bus.IN_X     = '0;
    bus.IN_Y     = '0;
    bus.IN_LAST  = 1'b0;
    bus.SOL_DONE = 1'b0;
    fork
      monitor_loop();
    join_none

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", w1(bus.IN_READY), 32'd0);
    check("rst_sol_valid", w1(bus.SOL_VALID), 32'd0);
    check("rst_sol_x", wc(bus.SOL_X), 32'd0);
    check("rst_sol_y", wc(bus.SOL_Y), 32'd0);
    check("rst_frame_err", w1(bus.FRAME_ERR), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    #1 check("ready_before_first_edge", w1(bus.IN_READY), 32'd0);
    @(negedge clk);
    check("ready_after_release", w1(bus.IN_READY), 32'd1);

    for (int k = 0; k < 7; k++) apply_frame(vecs[k]);

    // back-to-back frames with the solver holding bank A
    r0 = runs_done;
    send_frame(fa, 1'b1);
    c0 = cyc;
    send_frame(fb, 1'b1);
    check("b_load_cycles", cyc - c0, N);
    check("ready_both_full", w1(bus.IN_READY), 32'd0);
    bus.IN_VALID = 1'b1;
    bus.IN_X     = 4'h5;
    bus.IN_Y     = 4'ha;
    repeat (4) begin
      @(negedge clk);
      check("third_frame_ready", w1(bus.IN_READY), 32'd0);
    end
    bus.IN_VALID = 1'b0;
    wait_runs(r0 + 1);
    check("a_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
    check("ready_until_release", w1(bus.IN_READY), 32'd0);
    pulse_done();
    check("ready_one_after_release", w1(bus.IN_READY), 32'd1);
    check("b_lat1", w1(bus.SOL_VALID), 32'd0);
    @(negedge clk);
    check("b_lat2", w1(bus.SOL_VALID), 32'd1);
    wait_runs(r0 + 2);
    check("b_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
    pulse_done();

    // SOL_DONE during STREAM must be ignored
    r0 = runs_done;
    send_frame(fc, 1'b1);
    repeat (6) @(negedge clk);
    check("mid_stream_valid", w1(bus.SOL_VALID), 32'd1);
    pulse_done();
    check("done_ignored_state", 32'(dbg_state), 32'(STREAM));
    wait_runs(r0 + 1);
    check("c_wait_done", 32'(dbg_state), 32'(WAIT_DONE));
    repeat (3) @(negedge clk);
    check("c_still_waiting", 32'(dbg_state), 32'(WAIT_DONE));
    pulse_done();
    check("c_idle", 32'(dbg_state), 32'(IDLE));

    // reset at stream cycle 20
    send_frame(fd, 1'b1);
    @(negedge clk);
    check("d_stream_c1", w1(bus.SOL_VALID), 32'd1);
    repeat (19) @(negedge clk);
    check("d_stream_c20", w1(bus.SOL_VALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sol_valid", w1(bus.SOL_VALID), 32'd0);
    check("midrst_sol_x", wc(bus.SOL_X), 32'd0);
    check("midrst_sol_y", wc(bus.SOL_Y), 32'd0);
    check("midrst_in_ready", w1(bus.IN_READY), 32'd0);
    check("midrst_frame_err", w1(bus.FRAME_ERR), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", w1(bus.IN_READY), 32'd1);
    apply_frame(fe);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "time limit reached");
  end

endmodule
